// File: rtl/if_fetch_pkg.sv
// Shared definitions for the GeMIPS instruction-fetch stage: reset PC default,
// fetch FSM state encodings, NOP encoding and a word-alignment helper.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (output inst_req, output inst_addr, input inst_ack, input inst_rdata);
  modport slave  (input inst_req, input inst_addr, output inst_ack, output inst_rdata);
endinterface

// File: rtl/if_fetch_pc_next.sv
// Combinational next-fetch-address select (module if_pc_next): a live redirect
// wins over a pending one, otherwise the delivered address plus 4.
module if_pc_next
  import if_fetch_pkg::*;
(
  input  logic [31:0] base_addr,
  input  logic        pend,
  input  logic [31:0] pend_target,
  input  logic        live,
  input  logic [31:0] live_target,
  output logic [31:0] next_addr,
  output logic        redirect
);

  always_comb begin
    redirect  = pend | live;
    next_addr = base_addr + 32'd4;
    if (live) begin
      next_addr = word_align(live_target);
    end else if (pend) begin
      next_addr = pend_target;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// GeMIPS instruction-fetch stage: owns the PC, runs the imem handshake and the
// IF/ID register. Define GEMIPS_DELAY_SLOT_EN to deliver the post-branch word.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stop,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  if_fetch_if.master        imem,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        redir_pend;
  logic [31:0] redir_target;

  logic        issue;
  logic        capture;
  logic        bubble;
  logic        deliver;
  logic        from_hold;
  logic        branch_live;
  logic [31:0] del_addr;
  logic [31:0] del_inst;
  logic [31:0] next_addr;
  logic        redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    deliver   = 1'b0;
    from_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        issue     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.inst_ack) begin
          if (!if_stop) begin
            deliver = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (!if_stop) begin
          bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!if_stop) begin
          deliver   = 1'b1;
          from_hold = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Branches are only honoured when ID is not stalled; ID re-presents them otherwise.
  assign branch_live = branch_flag & ~if_stop;
  assign del_addr    = from_hold ? hold_pc   : imem.inst_addr;
  assign del_inst    = from_hold ? hold_inst : imem.inst_rdata;

  if_pc_next u_pc_next (
    .base_addr   (del_addr),
    .pend        (redir_pend),
    .pend_target (redir_target),
    .live        (branch_live),
    .live_target (branch_target),
    .next_addr   (next_addr),
    .redirect    (redirect)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      imem.inst_req  <= 1'b0;
      imem.inst_addr <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= 32'd0;
      if_inst        <= 32'd0;
      hold_pc        <= 32'd0;
      hold_inst      <= NOP;
      redir_pend     <= 1'b0;
      redir_target   <= 32'd0;
    end else begin
      if (issue) begin
        imem.inst_req  <= 1'b1;
        imem.inst_addr <= pc;
      end
      if (capture) begin
        hold_pc       <= imem.inst_addr;
        hold_inst     <= imem.inst_rdata;
        imem.inst_req <= 1'b0;
      end
      if (bubble) begin
        if_valid <= 1'b0;
      end
      if (deliver) begin
        imem.inst_req  <= 1'b1;
        imem.inst_addr <= next_addr;
        pc             <= next_addr;
        if_pc          <= del_addr;
        if (redirect) begin
          redir_pend <= 1'b0;
`ifdef GEMIPS_DELAY_SLOT_EN
          if_valid <= 1'b1;
          if_inst  <= del_inst;
`else
          if_valid <= 1'b0;
          if_inst  <= NOP;
`endif
        end else begin
          if_valid <= 1'b1;
          if_inst  <= del_inst;
        end
      end else if (branch_live) begin
        // The in-flight request completes; its word is consumed as the branch successor.
        redir_pend   <= 1'b1;
        redir_target <= word_align(branch_target);
      end
    end
  end

endmodule
